fb_rect_fill: RTL and testbench
===============================

Name: fb_rect_fill

Overview:
Rectangle-fill pixel generator that feeds one input port of the framebuffer write arbiter (addr/color stream with tvalid/tready).
- Accepts a rectangle command (two corners plus a colour) and emits one pixel beat per framebuffer address it covers, in row-major order.
- Used for screen clears and solid UI boxes, while the second arbiter port carries live pixel traffic.

Parameters:
FB_WIDTH, 640, framebuffer width in pixels (row stride in addresses)
FB_HEIGHT, 480, framebuffer height in pixels
X_BITS, 10, width of x coordinates
Y_BITS, 10, width of y coordinates
PIXEL_BITS, 12, colour width
AXI_ADDR_WIDTH, 20, framebuffer address width

Ports:
clk  input  1  clock; all logic on rising edge
reset_n  input  1  asynchronous, active-low reset
cmd_valid  input  1  command valid
cmd_ready  output  1  command accepted when cmd_valid && cmd_ready
cmd_x0  input  X_BITS  corner 0 x
cmd_y0  input  Y_BITS  corner 0 y
cmd_x1  input  X_BITS  corner 1 x
cmd_y1  input  Y_BITS  corner 1 y
cmd_color  input  PIXEL_BITS  fill colour
axi_tvalid  output  1  pixel beat valid
axi_tready  input  1  downstream accepts beat
addr  output  AXI_ADDR_WIDTH  pixel address = y*FB_WIDTH + x
color  output  PIXEL_BITS  pixel colour
busy  output  1  high while a command is in progress
done  output  1  one-cycle pulse after the last beat of a command

Behaviour:
- Reset: asynchronous on reset_n low, released synchronously.
  - state=IDLE, axi_tvalid=0, addr=0, color=0, busy=0, done=0.
  - cmd_ready=1 from the first cycle after release.
  - Reset mid-fill drops axi_tvalid immediately and abandons the command; no residual beats after release.
- States: IDLE, FILL. cmd_ready = (state==IDLE); busy = (state==FILL).
- IDLE, on command accept:
  - Normalise: xmin=min(x0,x1), xmax=max(x0,x1); same for y.
  - Register xmin, xmax, ymax, the current x and y, row_base=ymin*FB_WIDTH (constant multiply, shift-add), addr=row_base+xmin, and color.
  - Go to FILL; axi_tvalid=1 the next cycle (latency 1).
- FILL:
  - addr, color and axi_tvalid are held stable while axi_tvalid && !axi_tready.
  - On a beat (axi_tvalid && axi_tready):
    - x<xmax: x+1, addr+1.
    - x==xmax and y<ymax: x=xmin, y+1, row_base+=FB_WIDTH, addr=row_base+FB_WIDTH+xmin.
    - x==xmax and y==ymax: axi_tvalid=0 and done=1 next cycle; return to IDLE.
- One IDLE cycle always separates consecutive commands; cmd_ready is never high during FILL.
- Beat count = (xmax-xmin+1)*(ymax-ymin+1); a degenerate rectangle (x0==x1, y0==y1) emits exactly 1 beat.
- Address arithmetic is done at AXI_ADDR_WIDTH and wraps modulo 2^AXI_ADDR_WIDTH.
- color is constant for the whole command. Inputs are sampled only at accept; changing cmd_* during FILL has no effect.

Optional Feature:
FB_RECT_FILL_CLIP_EN
- Defined:
  - After normalisation, xmax is clamped to FB_WIDTH-1 and ymax to FB_HEIGHT-1.
  - If xmin>=FB_WIDTH or ymin>=FB_HEIGHT, the command is consumed, no beats are emitted, and done pulses the cycle after accept (state stays IDLE).
- Undefined:
  - Coordinates are used unmodified; out-of-range rectangles produce wrapped or out-of-frame addresses.
  - Bounds are the caller's responsibility.

Decomposition:
- Shared package fb_pkg:
  - default FB_WIDTH/FB_HEIGHT constants
  - fb_x_t/fb_y_t coordinate typedefs
  - fb_rect_t struct {x0,y0,x1,y1,color}
- One sub-module, fb_rect_norm:
  - combinational normalise (min/max swap) plus the optional clip and off-screen flag
  - reusable by a future line/outline generator
- Counters and FSM stay in fb_rect_fill.

Test Plan:
- Rect (2,3)-(4,4), colour 0xABC, axi_tready=1 -> 6 beats at addr 1922,1923,1924,2562,2563,2564, all colour 0xABC; first beat 1 cycle after accept; done 1 cycle after the 6th beat.
- Corners swapped, (4,4)-(2,3) -> identical 6-beat sequence.
- Same rect with axi_tready low for 5 cycles on the 3rd beat, then random toggling -> addr/color stable while stalled; no dropped or duplicated addresses; cmd_ready=0 until done.
- Single pixel (639,479) -> exactly 1 beat at addr 307199; done pulse; cmd_ready=1 the following cycle.
- reset_n low during the 4th beat of a 10x10 fill -> axi_tvalid=0 immediately; no beats after release; cmd_ready=1, busy=0.
- With FB_RECT_FILL_CLIP_EN: (630,470)-(700,500) -> 100 beats, first 301430, last 307199. (700,0)-(710,5) -> 0 beats, done 1 cycle after accept.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared framebuffer types and default geometry for the pixel generators.
package fb_pkg;

    localparam int unsigned FB_WIDTH_DEF       = 640;
    localparam int unsigned FB_HEIGHT_DEF      = 480;
    localparam int unsigned X_BITS_DEF         = 10;
    localparam int unsigned Y_BITS_DEF         = 10;
    localparam int unsigned PIXEL_BITS_DEF     = 12;
    localparam int unsigned AXI_ADDR_WIDTH_DEF = 20;

    typedef logic [X_BITS_DEF-1:0]     fb_x_t;
    typedef logic [Y_BITS_DEF-1:0]     fb_y_t;
    typedef logic [PIXEL_BITS_DEF-1:0] fb_color_t;

    typedef struct packed {
        fb_x_t     x0;
        fb_y_t     y0;
        fb_x_t     x1;
        fb_y_t     y1;
        fb_color_t color;
    } fb_rect_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } fill_state_e;

endpackage

// File: rtl/fb_rect_norm.sv
// Combinational rectangle normalise (corner min/max) with optional screen clip.
// Clipping is compiled in when FB_RECT_FILL_CLIP_EN is defined.
module fb_rect_norm
    import fb_pkg::*;
#(
    parameter int unsigned X_BITS    = X_BITS_DEF,
    parameter int unsigned Y_BITS    = Y_BITS_DEF,
    parameter int unsigned FB_WIDTH  = FB_WIDTH_DEF,
    parameter int unsigned FB_HEIGHT = FB_HEIGHT_DEF
) (
    input  logic [X_BITS-1:0] x0,
    input  logic [Y_BITS-1:0] y0,
    input  logic [X_BITS-1:0] x1,
    input  logic [Y_BITS-1:0] y1,
    output logic [X_BITS-1:0] xmin_c,
    output logic [X_BITS-1:0] xmax_c,
    output logic [Y_BITS-1:0] ymin_c,
    output logic [Y_BITS-1:0] ymax_c,
    output logic              off_c
);

`ifdef FB_RECT_FILL_CLIP_EN
    localparam bit CLIP_EN = 1'b1;
`else
    localparam bit CLIP_EN = 1'b0;
`endif

    logic [X_BITS-1:0] x_lo, x_hi;
    logic [Y_BITS-1:0] y_lo, y_hi;

    always_comb begin
        x_lo   = (x0 <= x1) ? x0 : x1;
        x_hi   = (x0 <= x1) ? x1 : x0;
        y_lo   = (y0 <= y1) ? y0 : y1;
        y_hi   = (y0 <= y1) ? y1 : y0;
        xmin_c = x_lo;
        xmax_c = x_hi;
        ymin_c = y_lo;
        ymax_c = y_hi;
        off_c  = 1'b0;
        // Clamp far corner to the last visible pixel; flag fully off-screen boxes
        if (CLIP_EN) begin
            if (32'(x_hi) > FB_WIDTH - 1)
                xmax_c = X_BITS'(FB_WIDTH - 1);
            if (32'(y_hi) > FB_HEIGHT - 1)
                ymax_c = Y_BITS'(FB_HEIGHT - 1);
            off_c = (32'(x_lo) >= FB_WIDTH) || (32'(y_lo) >= FB_HEIGHT);
        end
    end

endmodule

// File: rtl/fb_rect_fill.sv
// Rectangle-fill pixel generator: one addr/colour beat per covered pixel, row-major.
// Optional screen clipping via FB_RECT_FILL_CLIP_EN (see fb_rect_norm).
module fb_rect_fill
    import fb_pkg::*;
#(
    parameter int unsigned FB_WIDTH       = FB_WIDTH_DEF,
    parameter int unsigned FB_HEIGHT      = FB_HEIGHT_DEF,
    parameter int unsigned X_BITS         = X_BITS_DEF,
    parameter int unsigned Y_BITS         = Y_BITS_DEF,
    parameter int unsigned PIXEL_BITS     = PIXEL_BITS_DEF,
    parameter int unsigned AXI_ADDR_WIDTH = AXI_ADDR_WIDTH_DEF
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [X_BITS-1:0]         cmd_x0,
    input  logic [Y_BITS-1:0]         cmd_y0,
    input  logic [X_BITS-1:0]         cmd_x1,
    input  logic [Y_BITS-1:0]         cmd_y1,
    input  logic [PIXEL_BITS-1:0]     cmd_color,
    output logic                      axi_tvalid,
    input  logic                      axi_tready,
    output logic [AXI_ADDR_WIDTH-1:0] addr,
    output logic [PIXEL_BITS-1:0]     color,
    output logic                      busy,
    output logic                      done
);

    localparam int unsigned AW = AXI_ADDR_WIDTH;

    logic [X_BITS-1:0] n_xmin, n_xmax;
    logic [Y_BITS-1:0] n_ymin, n_ymax;
    logic              n_off;

    fb_rect_norm #(
        .X_BITS    (X_BITS),
        .Y_BITS    (Y_BITS),
        .FB_WIDTH  (FB_WIDTH),
        .FB_HEIGHT (FB_HEIGHT)
    ) u_norm (
        .x0     (cmd_x0),
        .y0     (cmd_y0),
        .x1     (cmd_x1),
        .y1     (cmd_y1),
        .xmin_c (n_xmin),
        .xmax_c (n_xmax),
        .ymin_c (n_ymin),
        .ymax_c (n_ymax),
        .off_c  (n_off)
    );

    fill_state_e           state_q, state_d;
    logic [X_BITS-1:0]     xmin_q, xmin_d, xmax_q, xmax_d, x_q, x_d;
    logic [Y_BITS-1:0]     ymax_q, ymax_d, y_q, y_d;
    logic [AW-1:0]         row_base_q, row_base_d, addr_q, addr_d;
    logic [PIXEL_BITS-1:0] color_q, color_d;
    logic                  tvalid_q, tvalid_d;
    logic                  ready_q, ready_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  beat;
    logic [AW-1:0]         new_row_base;

    assign beat         = tvalid_q && axi_tready;
    // Constant multiply by the row stride; synthesis reduces it to shift-add
    assign new_row_base = AW'(n_ymin) * AW'(FB_WIDTH);

    // State register and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            xmin_q     <= '0;
            xmax_q     <= '0;
            x_q        <= '0;
            ymax_q     <= '0;
            y_q        <= '0;
            row_base_q <= '0;
            addr_q     <= '0;
            color_q    <= '0;
            tvalid_q   <= 1'b0;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            xmin_q     <= xmin_d;
            xmax_q     <= xmax_d;
            x_q        <= x_d;
            ymax_q     <= ymax_d;
            y_q        <= y_d;
            row_base_q <= row_base_d;
            addr_q     <= addr_d;
            color_q    <= color_d;
            tvalid_q   <= tvalid_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d    = state_q;
        xmin_d     = xmin_q;
        xmax_d     = xmax_q;
        x_d        = x_q;
        ymax_d     = ymax_q;
        y_d        = y_q;
        row_base_d = row_base_q;
        addr_d     = addr_q;
        color_d    = color_q;
        tvalid_d   = tvalid_q;
        ready_d    = ready_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && ready_q) begin
                    if (n_off) begin
                        done_d = 1'b1;
                    end else begin
                        xmin_d     = n_xmin;
                        xmax_d     = n_xmax;
                        x_d        = n_xmin;
                        ymax_d     = n_ymax;
                        y_d        = n_ymin;
                        row_base_d = new_row_base;
                        addr_d     = new_row_base + AW'(n_xmin);
                        color_d    = cmd_color;
                        tvalid_d   = 1'b1;
                        ready_d    = 1'b0;
                        busy_d     = 1'b1;
                        state_d    = ST_FILL;
                    end
                end
            end
            ST_FILL: begin
                if (beat) begin
                    if (x_q < xmax_q) begin
                        x_d    = x_q + X_BITS'(1);
                        addr_d = addr_q + AW'(1);
                    end else if (y_q < ymax_q) begin
                        x_d        = xmin_q;
                        y_d        = y_q + Y_BITS'(1);
                        row_base_d = row_base_q + AW'(FB_WIDTH);
                        addr_d     = row_base_q + AW'(FB_WIDTH) + AW'(xmin_q);
                    end else begin
                        tvalid_d = 1'b0;
                        done_d   = 1'b1;
                        ready_d  = 1'b1;
                        busy_d   = 1'b0;
                        state_d  = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d  = ST_IDLE;
                tvalid_d = 1'b0;
                ready_d  = 1'b1;
                busy_d   = 1'b0;
            end
        endcase
    end

    assign cmd_ready  = ready_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign axi_tvalid = tvalid_q;
    assign addr       = addr_q;
    assign color      = color_q;

endmodule

// File: tb/tb_fb_rect_fill.sv
// Directed bench for fb_rect_fill with an expected-beat scoreboard.
module tb_fb_rect_fill;

    localparam int unsigned FBW = 640;
    localparam int unsigned FBH = 480;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [9:0]  cmd_x0, cmd_y0, cmd_x1, cmd_y1;
    logic [11:0] cmd_color;
    logic        axi_tvalid;
    logic        axi_tready;
    logic [19:0] addr;
    logic [11:0] color;
    logic        busy;
    logic        done;

    logic [31:0] exp_q[$];
    int          n_assert = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    fb_rect_fill dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_x0     (cmd_x0),
        .cmd_y0     (cmd_y0),
        .cmd_x1     (cmd_x1),
        .cmd_y1     (cmd_y1),
        .cmd_color  (cmd_color),
        .axi_tvalid (axi_tvalid),
        .axi_tready (axi_tready),
        .addr       (addr),
        .color      (color),
        .busy       (busy),
        .done       (done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    // Reference model: enumerate covered pixels directly from the corners
    task automatic push_rect(input int x0, input int y0, input int x1, input int y1,
                             input logic [11:0] col, output int n);
        int xl, xh, yl, yh;
        logic [19:0] a;
        xl = (x0 < x1) ? x0 : x1;
        xh = (x0 < x1) ? x1 : x0;
        yl = (y0 < y1) ? y0 : y1;
        yh = (y0 < y1) ? y1 : y0;
        n  = 0;
`ifdef FB_RECT_FILL_CLIP_EN
        if (xl >= int'(FBW) || yl >= int'(FBH)) return;
        if (xh > int'(FBW) - 1) xh = int'(FBW) - 1;
        if (yh > int'(FBH) - 1) yh = int'(FBH) - 1;
`endif
        for (int y = yl; y <= yh; y++) begin
            for (int x = xl; x <= xh; x++) begin
                a = 20'(y * int'(FBW) + x);
                exp_q.push_back({a, col});
                n++;
            end
        end
    endtask

    // Scoreboard: every presented beat must match the head of the queue
    always @(negedge clk) begin
        if (reset_n === 1'b1 && axi_tvalid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("extra_beat", 32'(axi_tvalid), 32'd0);
            end else begin
                check("beat_addr", 32'(addr), 32'(exp_q[0][31:12]));
                check("beat_color", 32'(color), 32'(exp_q[0][11:0]));
                if (axi_tready === 1'b1) void'(exp_q.pop_front());
            end
        end
    end

    // mode 0: tready always high; mode 1: stall 3rd beat 5 cycles then random
    task automatic run_rect(input int x0, input int y0, input int x1, input int y1,
                            input logic [11:0] col, input int mode, input int exp_done_k);
        int n;
        int k;
        bit seen;
        push_rect(x0, y0, x1, y1, col, n);
        @(posedge clk); #1;
        cmd_x0     = 10'(x0);
        cmd_y0     = 10'(y0);
        cmd_x1     = 10'(x1);
        cmd_y1     = 10'(y1);
        cmd_color  = col;
        cmd_valid  = 1'b1;
        axi_tready = 1'b1;
        check("ready_idle", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_x0    = 10'($urandom);
        cmd_y0    = 10'($urandom);
        cmd_x1    = 10'($urandom);
        cmd_y1    = 10'($urandom);
        cmd_color = 12'($urandom);
        seen = 1'b0;
        for (k = 1; k <= 300; k++) begin
            if (mode == 1)
                axi_tready = (k >= 3 && k <= 7) ? 1'b0 :
                             (k >= 8) ? 1'($urandom_range(0, 1)) : 1'b1;
            else
                axi_tready = 1'b1;
            @(negedge clk);
            if (k == 1) begin
                check("first_valid", 32'(axi_tvalid), 32'(n > 0));
                check("busy_fill", 32'(busy), 32'(n > 0));
            end
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            check("ready_fill", 32'(cmd_ready), 32'd0);
            @(posedge clk); #1;
        end
        check("done_seen", 32'(seen), 32'd1);
        if (exp_done_k > 0) check("done_cycle", 32'(k), 32'(exp_done_k));
        check("beats_left", 32'(exp_q.size()), 32'd0);
        check("ready_after", 32'(cmd_ready), 32'd1);
        check("valid_after", 32'(axi_tvalid), 32'd0);
        @(negedge clk);
        check("done_pulse", 32'(done), 32'd0);
        check("busy_after", 32'(busy), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        int n;
        reset_n    = 1'b0;
        cmd_valid  = 1'b0;
        cmd_x0     = '0;
        cmd_y0     = '0;
        cmd_x1     = '0;
        cmd_y1     = '0;
        cmd_color  = '0;
        axi_tready = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_valid", 32'(axi_tvalid), 32'd0);
        check("rst_addr", 32'(addr), 32'd0);
        check("rst_color", 32'(color), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("rst_ready", 32'(cmd_ready), 32'd1);

        run_rect(2, 3, 4, 4, 12'hABC, 0, 7);
        run_rect(4, 4, 2, 3, 12'hABC, 0, 7);
        run_rect(2, 3, 4, 4, 12'hABC, 1, -1);
        run_rect(639, 479, 639, 479, 12'h3C5, 0, 2);
`ifdef FB_RECT_FILL_CLIP_EN
        run_rect(630, 470, 700, 500, 12'h0F0, 0, 101);
        run_rect(700, 0, 710, 5, 12'hF00, 0, 1);
`else
        run_rect(700, 0, 703, 1, 12'h0F0, 0, 9);
`endif

        // Reset during the 4th beat of a 10x10 fill
        push_rect(0, 0, 9, 9, 12'h5A5, n);
        @(posedge clk); #1;
        cmd_x0     = 10'd0;
        cmd_y0     = 10'd0;
        cmd_x1     = 10'd9;
        cmd_y1     = 10'd9;
        cmd_color  = 12'h5A5;
        cmd_valid  = 1'b1;
        axi_tready = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            @(posedge clk); #1;
        end
        check("pre_reset_left", 32'(exp_q.size()), 32'(n - 3));
        check("pre_reset_valid", 32'(axi_tvalid), 32'd1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(axi_tvalid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("post_rst_valid", 32'(axi_tvalid), 32'd0);
        end
        check("post_rst_ready", 32'(cmd_ready), 32'd1);
        check("post_rst_busy", 32'(busy), 32'd0);

        run_rect(1, 1, 0, 0, 12'h777, 0, 5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
